// File: rtl/fcmp_arb_ctrl.sv
// rtl/fcmp_arb_ctrl.sv - round-robin arbiter sequencing two requesters through one IEEE-754 FEQ/FLT/FLE compare
module fcmp_arb_ctrl #(
  parameter logic        RR_INIT    = 1'b0,
  parameter logic [31:0] CANON_QNAN = 32'h7FC0_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0_VALID,
  output logic        REQ0_READY,
  input  logic [1:0]  REQ0_FUNCT,
  input  logic [31:0] REQ0_OP_A,
  input  logic [31:0] REQ0_OP_B,
  input  logic        REQ1_VALID,
  output logic        REQ1_READY,
  input  logic [1:0]  REQ1_FUNCT,
  input  logic [31:0] REQ1_OP_A,
  input  logic [31:0] REQ1_OP_B,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic        RSP_ID,
  output logic [31:0] RSP_R,
  output logic        RSP_NV,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CLASSIFY = 2'd1,
    S_COMPARE  = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  localparam logic [1:0] F_FLE = 2'b00;
  localparam logic [1:0] F_FLT = 2'b01;
  localparam logic [1:0] F_FEQ = 2'b10;

  state_t      state_q;
  logic        prio_q;
  logic        id_q;
  logic [1:0]  funct_q;
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        a_nan_q, a_snan_q, a_zero_q;
  logic        b_nan_q, b_snan_q, b_zero_q;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic        rsp_r_q;
  logic        rsp_nv_q;

  function automatic logic is_nan(input logic [31:0] x);
    return (x == CANON_QNAN) || ((x[30:23] == 8'hFF) && (x[22:0] != 23'd0));
  endfunction

  function automatic logic is_snan(input logic [31:0] x);
    return is_nan(x) && !x[22];
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  // RST gates the grants so neither READY can rise while reset is held.
  logic idle;
  logic grant0;
  logic grant1;

  assign idle   = (state_q == S_IDLE) && RST;
  assign grant0 = idle && REQ0_VALID && (!REQ1_VALID || (prio_q == 1'b0));
  assign grant1 = idle && REQ1_VALID && (!REQ0_VALID || (prio_q == 1'b1));

  assign REQ0_READY = grant0;
  assign REQ1_READY = grant1;
  assign RSP_VALID  = rsp_valid_q;
  assign RSP_ID     = rsp_id_q;
  assign RSP_R      = {31'd0, rsp_r_q};
  assign RSP_NV     = rsp_nv_q;
  assign BUSY       = (state_q != S_IDLE);

  logic any_nan;
  logic any_snan;
  logic eq_d;
  logic lt_d;
  logic r_d;
  logic nv_d;

  always_comb begin
    any_nan  = a_nan_q || b_nan_q;
    any_snan = a_snan_q || b_snan_q;
    eq_d     = 1'b0;
    lt_d     = 1'b0;
    r_d      = 1'b0;
    nv_d     = 1'b0;

    // Sign-magnitude order: for two negatives the larger magnitude is the smaller value.
    if (a_zero_q && b_zero_q) begin
      eq_d = 1'b1;
      lt_d = 1'b0;
    end else begin
      eq_d = (op_a_q == op_b_q);
      if (op_a_q[31] != op_b_q[31]) begin
        lt_d = op_a_q[31];
      end else if (!op_a_q[31]) begin
        lt_d = op_a_q[30:0] < op_b_q[30:0];
      end else begin
        lt_d = op_a_q[30:0] > op_b_q[30:0];
      end
    end

    case (funct_q)
      F_FLE: begin
        r_d  = lt_d || eq_d;
        nv_d = any_nan;
      end
      F_FLT: begin
        r_d  = lt_d;
        nv_d = any_nan;
      end
      F_FEQ: begin
        r_d  = eq_d;
        nv_d = any_snan;
      end
      default: begin
        r_d  = 1'b0;
        nv_d = 1'b1;
      end
    endcase

    if (any_nan) begin
      r_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      prio_q      <= RR_INIT;
      id_q        <= 1'b0;
      funct_q     <= 2'b00;
      op_a_q      <= 32'd0;
      op_b_q      <= 32'd0;
      a_nan_q     <= 1'b0;
      a_snan_q    <= 1'b0;
      a_zero_q    <= 1'b0;
      b_nan_q     <= 1'b0;
      b_snan_q    <= 1'b0;
      b_zero_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_r_q     <= 1'b0;
      rsp_nv_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant0 || grant1) begin
            op_a_q  <= grant1 ? REQ1_OP_A : REQ0_OP_A;
            op_b_q  <= grant1 ? REQ1_OP_B : REQ0_OP_B;
            funct_q <= grant1 ? REQ1_FUNCT : REQ0_FUNCT;
            id_q    <= grant1;
            prio_q  <= grant0;
            state_q <= S_CLASSIFY;
          end
        end
        S_CLASSIFY: begin
          a_nan_q  <= is_nan(op_a_q);
          a_snan_q <= is_snan(op_a_q);
          a_zero_q <= is_zero(op_a_q);
          b_nan_q  <= is_nan(op_b_q);
          b_snan_q <= is_snan(op_b_q);
          b_zero_q <= is_zero(op_b_q);
          state_q  <= S_COMPARE;
        end
        S_COMPARE: begin
          rsp_r_q     <= r_d;
          rsp_nv_q    <= nv_d;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= S_RESP;
        end
        S_RESP: begin
          if (RSP_READY) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcmp_arb_ctrl.sv
// tb/tb_fcmp_arb_ctrl.sv - randomized and directed bench for fcmp_arb_ctrl against an ordered-integer compare model
module tb_fcmp_arb_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ0_VALID, REQ0_READY;
  logic [1:0]  REQ0_FUNCT;
  logic [31:0] REQ0_OP_A, REQ0_OP_B;
  logic        REQ1_VALID, REQ1_READY;
  logic [1:0]  REQ1_FUNCT;
  logic [31:0] REQ1_OP_A, REQ1_OP_B;
  logic        RSP_VALID, RSP_READY, RSP_ID, RSP_NV, BUSY;
  logic [31:0] RSP_R;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 CLK = ~CLK;

  fcmp_arb_ctrl #(.RR_INIT(1'b0), .CANON_QNAN(32'h7FC0_0000)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_FUNCT(REQ0_FUNCT),
    .REQ0_OP_A(REQ0_OP_A), .REQ0_OP_B(REQ0_OP_B),
    .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_FUNCT(REQ1_FUNCT),
    .REQ1_OP_A(REQ1_OP_A), .REQ1_OP_B(REQ1_OP_B),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_R(RSP_R), .RSP_NV(RSP_NV), .BUSY(BUSY)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Floats map onto a signed integer line (+0 and -0 both land on 0), so ordering is plain integer compare.
  function automatic longint fkey(input logic [31:0] x);
    return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
  endfunction

  function automatic void ref_cmp(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic nv);
    bit an, bn, as_, bs_;
    an  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    bn  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    as_ = an && !a[22];
    bs_ = bn && !b[22];
    r   = 32'd0;
    nv  = 1'b0;
    if (f == 2'b11) begin
      nv = 1'b1;
    end else if (an || bn) begin
      nv = (f == 2'b10) ? (as_ || bs_) : 1'b1;
    end else begin
      case (f)
        2'b10:   r = (fkey(a) == fkey(b)) ? 32'd1 : 32'd0;
        2'b01:   r = (fkey(a) <  fkey(b)) ? 32'd1 : 32'd0;
        default: r = (fkey(a) <= fkey(b)) ? 32'd1 : 32'd0;
      endcase
    end
  endfunction

  function automatic logic [31:0] rand_op(input logic [31:0] other);
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 8))
      0: v = {v[31], 31'd0};
      1: v = {v[31], 8'hFF, 23'd0};
      2: v = {v[31], 8'hFF, 1'b1, v[21:0]};
      3: v = {v[31], 8'hFF, 1'b0, v[21:1], 1'b1};
      4: v = other;
      5: v = {~other[31], other[30:0]};
      6: v = {v[31], 8'd0, v[22:0]};
      default: ;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    REQ0_VALID = 1'b0; REQ0_FUNCT = 2'b00; REQ0_OP_A = 32'd0; REQ0_OP_B = 32'd0;
    REQ1_VALID = 1'b0; REQ1_FUNCT = 2'b00; REQ1_OP_A = 32'd0; REQ1_OP_B = 32'd0;
    RSP_READY  = 1'b0;
  endtask

  // Drives one request, returns what the response carried and how many negedges after transfer it appeared.
  task automatic issue(input bit id, input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int rsp_delay, output logic [31:0] r, output logic nv, output logic rid,
                       output int lat, output bit ok);
    int n;
    ok = 1'b0; lat = 0; r = 32'd0; nv = 1'b0; rid = 1'b0;
    @(negedge CLK);
    if (id == 1'b0) begin
      REQ0_VALID = 1'b1; REQ0_FUNCT = f; REQ0_OP_A = a; REQ0_OP_B = b;
    end else begin
      REQ1_VALID = 1'b1; REQ1_FUNCT = f; REQ1_OP_A = a; REQ1_OP_B = b;
    end
    #1;
    n = 0;
    while (!(id ? REQ1_READY : REQ0_READY) && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 20) begin
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    lat = 1;
    while (!RSP_VALID && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    if (!RSP_VALID) return;
    r = RSP_R; nv = RSP_NV; rid = RSP_ID;
    repeat (rsp_delay) @(negedge CLK);
    RSP_READY = 1'b1;
    @(negedge CLK);
    RSP_READY = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1'b0;
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    tests_run++;
    if ({REQ0_READY, REQ1_READY, RSP_VALID, BUSY, RSP_ID, RSP_NV} !== 6'b0 || RSP_R !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%b%b vld=%b busy=%b id=%b nv=%b r=%h, want all zero",
               REQ0_READY, REQ1_READY, RSP_VALID, BUSY, RSP_ID, RSP_NV, RSP_R);
    end
    idle_inputs();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_directed();
    bit          t_id [9] = '{0, 1, 1, 0, 0, 0, 0, 1, 1};
    logic [1:0]  t_f  [9] = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11};
    logic [31:0] t_a  [9] = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 32'h0000_0000, 32'h0000_0000,
                             32'h7FC0_0000, 32'h7F80_0001, 32'h7FC0_0000, 32'h3F80_0000};
    logic [31:0] t_b  [9] = '{32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000, 32'h8000_0000, 32'h8000_0000,
                             32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
    logic [31:0] t_r  [9] = '{32'd1, 32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic        t_nv [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] r;
    logic        nv, rid;
    int          lat;
    bit          ok;
    for (int i = 0; i < 9; i++) begin
      issue(t_id[i], t_f[i], t_a[i], t_b[i], i % 3, r, nv, rid, lat, ok);
      tests_run++;
      if (!ok || lat !== 3 || r !== t_r[i] || nv !== t_nv[i] || rid !== t_id[i]) begin
        tests_failed++;
        $display("FAIL directed_%0d: got ok=%0d lat=%0d r=%h nv=%b id=%b, want lat=3 r=%h nv=%b id=%b",
                 i, ok, lat, r, nv, rid, t_r[i], t_nv[i], t_id[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, er;
    logic [1:0]  f;
    logic        nv, env, rid;
    bit          id, ok;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      id = 1'($urandom_range(0, 1));
      f  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = rand_op($urandom);
      b  = rand_op(a);
      ref_cmp(f, a, b, er, env);
      issue(id, f, a, b, $urandom_range(0, 3), r, nv, rid, lat, ok);
      tests_run++;
      if (!ok || lat !== 3 || r !== er || nv !== env || rid !== id) begin
        tests_failed++;
        $display("FAIL random_%0d f=%b a=%h b=%h: got ok=%0d lat=%0d r=%h nv=%b id=%b, want lat=3 r=%h nv=%b id=%b",
                 i, f, a, b, ok, lat, r, nv, rid, er, env, id);
      end
    end
  endtask

  task automatic test_round_robin_backpressure();
    int          grants[$];
    int          n;
    bit          both_seen, held_ok;
    logic [31:0] a1, b1, er, hr;
    logic [1:0]  f1;
    logic        env, hnv, hid;
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    a1 = rand_op($urandom); b1 = rand_op(a1); f1 = 2'($urandom_range(0, 2));
    ref_cmp(f1, a1, b1, er, env);
    REQ0_VALID = 1'b1; REQ0_FUNCT = 2'($urandom_range(0, 2)); REQ0_OP_A = $urandom; REQ0_OP_B = $urandom;
    REQ1_VALID = 1'b1; REQ1_FUNCT = f1; REQ1_OP_A = a1; REQ1_OP_B = b1;
    RSP_READY  = 1'b1;
    n = 0; both_seen = 1'b0;
    while (n < 80) begin
      #1;
      if (REQ0_READY && REQ1_READY) both_seen = 1'b1;
      if (REQ0_READY) grants.push_back(0);
      else if (REQ1_READY) grants.push_back(1);
      if (grants.size() == 4) begin
        RSP_READY = 1'b0;
        break;
      end
      @(negedge CLK);
      n++;
    end
    tests_run++;
    if (grants.size() != 4 || both_seen) begin
      tests_failed++;
      $display("FAIL rr_grant_count: got %0d grants both_ready=%0d, want 4 grants both_ready=0", grants.size(), both_seen);
    end
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      tests_run++;
      if (grants[i] != i % 2) begin
        tests_failed++;
        $display("FAIL rr_grant_%0d: got requester %0d, want %0d", i, grants[i], i % 2);
      end
    end
    n = 0;
    @(negedge CLK);
    while (!RSP_VALID && n < 20) begin
      @(negedge CLK);
      n++;
    end
    hr = RSP_R; hnv = RSP_NV; hid = RSP_ID;
    tests_run++;
    if (!RSP_VALID || hid !== 1'b1 || hr !== er || hnv !== env) begin
      tests_failed++;
      $display("FAIL rr_held_rsp: got vld=%b id=%b r=%h nv=%b, want vld=1 id=1 r=%h nv=%b", RSP_VALID, hid, hr, hnv, er, env);
    end
    held_ok = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      if (!RSP_VALID || RSP_R !== hr || RSP_NV !== hnv || RSP_ID !== hid || REQ0_READY || REQ1_READY || !BUSY)
        held_ok = 1'b0;
    end
    tests_run++;
    if (!held_ok) begin
      tests_failed++;
      $display("FAIL backpressure_hold: got vld=%b r=%h nv=%b id=%b rdy=%b%b busy=%b, want held response, no grant, busy=1",
               RSP_VALID, RSP_R, RSP_NV, RSP_ID, REQ0_READY, REQ1_READY, BUSY);
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    RSP_READY  = 1'b1;
    @(negedge CLK);
    RSP_READY  = 1'b0;
    tests_run++;
    if (RSP_VALID !== 1'b0 || BUSY !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release: got vld=%b busy=%b, want 0 0", RSP_VALID, BUSY);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] r;
    logic        nv, rid;
    int          lat, n;
    bit          ok, stray;
    issue(1'b0, 2'b10, 32'h3F80_0000, 32'h3F80_0000, 0, r, nv, rid, lat, ok);
    @(negedge CLK);
    REQ0_VALID = 1'b1; REQ0_FUNCT = 2'b00; REQ0_OP_A = 32'h3F80_0000; REQ0_OP_B = 32'h4000_0000;
    #1;
    n = 0;
    while (!REQ0_READY && n < 20) begin
      @(negedge CLK);
      n++;
    end
    @(posedge CLK);
    @(negedge CLK);
    REQ0_VALID = 1'b0;
    @(negedge CLK);
    tests_run++;
    if (BUSY !== 1'b1 || RSP_VALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL midop_in_compare: got busy=%b vld=%b, want busy=1 vld=0", BUSY, RSP_VALID);
    end
    REQ0_VALID = 1'b1; REQ1_VALID = 1'b1;
    RST = 1'b0;
    #1;
    tests_run++;
    if ({REQ0_READY, REQ1_READY, RSP_VALID, BUSY, RSP_ID, RSP_NV} !== 6'b0 || RSP_R !== 32'd0) begin
      tests_failed++;
      $display("FAIL midop_reset_outputs: got rdy=%b%b vld=%b busy=%b id=%b nv=%b r=%h, want all zero",
               REQ0_READY, REQ1_READY, RSP_VALID, BUSY, RSP_ID, RSP_NV, RSP_R);
    end
    REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    stray = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (RSP_VALID || BUSY) stray = 1'b1;
    end
    tests_run++;
    if (stray) begin
      tests_failed++;
      $display("FAIL midop_no_response: got a response or busy after reset, want none");
    end
    issue(1'b1, 2'b01, 32'hC000_0000, 32'h8000_0000, 1, r, nv, rid, lat, ok);
    tests_run++;
    if (!ok || lat !== 3 || r !== 32'd1 || nv !== 1'b0 || rid !== 1'b1) begin
      tests_failed++;
      $display("FAIL midop_recover: got ok=%0d lat=%0d r=%h nv=%b id=%b, want lat=3 r=1 nv=0 id=1", ok, lat, r, nv, rid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_round_robin_backpressure();
    test_reset_mid_op();
    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
